// File: rtl/alu_issue.sv
// Execute-stage initiator: decodes OP/OP-IMM/BRANCH bundles into the ALU's
// op/operand registers and returns the ALU's result over a valid/ready handshake.
module alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_fault,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_taken,
  output logic        out_is_branch,
  output logic        out_fault
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        local_fault_r;
  logic        is_branch_r;
  logic        accept_s;
  logic        resp_s;
  logic        fault_s;
  logic [6:0]  opcode_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [4:0]  dec_op_s;
  logic [31:0] dec_a_s;
  logic [31:0] dec_b_s;
  logic        dec_fault_s;
  logic        dec_branch_s;

  assign opcode_s = in_instr[6:0];
  assign f3_s     = in_instr[14:12];
  assign f7_s     = in_instr[31:25];
  assign accept_s = (state_r == IDLE) && in_valid;
  assign resp_s   = (state_r == RESP);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_next_s = ISSUE;
        else          state_next_s = IDLE;
      end
      ISSUE: state_next_s = RESP;
      RESP: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = RESP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Instruction decode; unknown opcodes map to the ALU's invalid op 11111
  always_comb begin
    dec_op_s     = 5'b11111;
    dec_a_s      = 32'd0;
    dec_b_s      = 32'd0;
    dec_fault_s  = 1'b1;
    dec_branch_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        dec_op_s    = {1'b0, f7_s[5], f3_s};
        dec_a_s     = in_rs1;
        dec_b_s     = in_rs2;
        dec_fault_s = !((f7_s == F7_BASE) || (f7_s == F7_ALT));
      end
      OPC_OP_IMM: begin
        // Only SRAI uses imm[10] as an op bit; ADDI must never turn into SUB
        dec_op_s = {1'b0, (f3_s == 3'b101) & f7_s[5], f3_s};
        dec_a_s  = in_rs1;
        dec_b_s  = {{20{in_instr[31]}}, in_instr[31:20]};
        if (f3_s == 3'b001) begin
          dec_fault_s = (f7_s != F7_BASE);
        end else if (f3_s == 3'b101) begin
          dec_fault_s = !((f7_s == F7_BASE) || (f7_s == F7_ALT));
        end else begin
          dec_fault_s = 1'b0;
        end
      end
      OPC_BRANCH: begin
        dec_op_s     = {2'b10, f3_s};
        dec_a_s      = in_rs1;
        dec_b_s      = in_rs2;
        dec_fault_s  = 1'b0;
        dec_branch_s = 1'b1;
      end
      default: begin
        dec_op_s     = 5'b11111;
        dec_a_s      = 32'd0;
        dec_b_s      = 32'd0;
        dec_fault_s  = 1'b1;
        dec_branch_s = 1'b0;
      end
    endcase
  end

  // Operand/flag capture at accept, plus registered handshake flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op        <= 5'b00000;
      alu_a         <= 32'd0;
      alu_b         <= 32'd0;
      local_fault_r <= 1'b0;
      is_branch_r   <= 1'b0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
    end else begin
      if (accept_s) begin
        alu_op        <= dec_op_s;
        alu_a         <= dec_a_s;
        alu_b         <= dec_b_s;
        local_fault_r <= dec_fault_s;
        is_branch_r   <= dec_branch_s;
      end
      in_ready  <= (state_next_s == IDLE);
      out_valid <= (state_next_s == RESP);
    end
  end

  assign fault_s = local_fault_r | alu_fault;

  // Result bundle follows the ALU directly; quiet outside RESP
  always_comb begin
    out_result    = 32'd0;
    out_taken     = 1'b0;
    out_is_branch = 1'b0;
    out_fault     = 1'b0;
    if (resp_s) begin
      out_fault     = fault_s;
      out_is_branch = is_branch_r;
      out_taken     = is_branch_r & alu_out[0] & ~fault_s;
      out_result    = fault_s ? 32'd0 : alu_out;
    end else begin
      out_result    = 32'd0;
    end
  end

endmodule
